// File: rtl/corr_sync_if.sv
// Bundles the stream ports of corr_sync. The master side drives the input
// bitstreams and controls. The slave side is the correlation manipulator.
interface corr_sync_if #(
  parameter int CW = 2
);
  logic          in_valid;
  logic          in_a;
  logic          in_b;
  logic          mode;
  logic          flush;
  logic          out_valid;
  logic          out_a;
  logic          out_b;
  logic [CW-1:0] cnt_a;
  logic [CW-1:0] cnt_b;
  logic          busy;

  modport master (
    output in_valid, in_a, in_b, mode, flush,
    input  out_valid, out_a, out_b, cnt_a, cnt_b, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, mode, flush,
    output out_valid, out_a, out_b, cnt_a, cnt_b, busy
  );
endinterface

// File: rtl/corr_sync.sv
// Stochastic-computing correlation manipulator. It reorders the 1-bits of two
// bitstreams so that the streams become positively correlated (mode=0) or
// negatively correlated (mode=1). Each stream has a small save counter. The
// counter holds 1-bits that were taken out of the stream and not yet
// re-emitted, so the number of 1-bits in each stream is preserved.
module corr_sync #(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input logic         clk,
  input logic         rst_n,
  corr_sync_if.slave  bus
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [CW-1:0] cnt_a_q, cnt_a_d;
  logic [CW-1:0] cnt_b_q, cnt_b_d;
  logic          out_a_q, out_a_d;
  logic          out_b_q, out_b_d;
  logic          valid_q;

  assign bus.out_valid = valid_q;
  assign bus.out_a     = out_a_q;
  assign bus.out_b     = out_b_q;
  assign bus.cnt_a     = cnt_a_q;
  assign bus.cnt_b     = cnt_b_q;
  assign bus.busy      = (cnt_a_q != ZERO_C) || (cnt_b_q != ZERO_C);

  // Next-state rules. The priority is invalid, then flush, then mode.
  // A counter only moves by one step, and only when it is not at a limit,
  // so it can never wrap.
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    out_a_d = 1'b0;
    out_b_d = 1'b0;
    if (!bus.in_valid) begin
      out_a_d = 1'b0;
      out_b_d = 1'b0;
    end else if (bus.flush) begin
      // Each stream drains on its own. Input 1-bits pass through, and a 0
      // slot is filled from the saved bits when any are held.
      if (bus.in_a) begin
        out_a_d = 1'b1;
      end else if (cnt_a_q != ZERO_C) begin
        out_a_d = 1'b1;
        cnt_a_d = cnt_a_q - ONE_C;
      end else begin
        out_a_d = 1'b0;
      end
      if (bus.in_b) begin
        out_b_d = 1'b1;
      end else if (cnt_b_q != ZERO_C) begin
        out_b_d = 1'b1;
        cnt_b_d = cnt_b_q - ONE_C;
      end else begin
        out_b_d = 1'b0;
      end
    end else if (!bus.mode) begin
      // Synchronise. A lone 1-bit is either paired with a bit saved on the
      // other stream, or held back until a partner arrives. Because a bit is
      // held only when the other counter is empty, at most one counter is
      // nonzero.
      case ({bus.in_a, bus.in_b})
        2'b10: begin
          if (cnt_b_q != ZERO_C) begin
            out_a_d = 1'b1;
            out_b_d = 1'b1;
            cnt_b_d = cnt_b_q - ONE_C;
          end else if (cnt_a_q < DEPTH_C) begin
            cnt_a_d = cnt_a_q + ONE_C;
          end else begin
            out_a_d = 1'b1;
          end
        end
        2'b01: begin
          if (cnt_a_q != ZERO_C) begin
            out_a_d = 1'b1;
            out_b_d = 1'b1;
            cnt_a_d = cnt_a_q - ONE_C;
          end else if (cnt_b_q < DEPTH_C) begin
            cnt_b_d = cnt_b_q + ONE_C;
          end else begin
            out_b_d = 1'b1;
          end
        end
        default: begin
          out_a_d = bus.in_a;
          out_b_d = bus.in_b;
        end
      endcase
    end else begin
      // Desynchronise. Overlapping 1-bits are split apart by saving one of
      // them. The saved bit is emitted later in a slot where both inputs
      // are 0.
      case ({bus.in_a, bus.in_b})
        2'b11: begin
          if (cnt_a_q < DEPTH_C) begin
            out_b_d = 1'b1;
            cnt_a_d = cnt_a_q + ONE_C;
          end else if (cnt_b_q < DEPTH_C) begin
            out_a_d = 1'b1;
            cnt_b_d = cnt_b_q + ONE_C;
          end else begin
            out_a_d = 1'b1;
            out_b_d = 1'b1;
          end
        end
        2'b00: begin
          if (cnt_a_q != ZERO_C) begin
            out_a_d = 1'b1;
            cnt_a_d = cnt_a_q - ONE_C;
          end else if (cnt_b_q != ZERO_C) begin
            out_b_d = 1'b1;
            cnt_b_d = cnt_b_q - ONE_C;
          end else begin
            out_a_d = 1'b0;
            out_b_d = 1'b0;
          end
        end
        default: begin
          out_a_d = bus.in_a;
          out_b_d = bus.in_b;
        end
      endcase
    end
  end

  // Register the counters and the outputs. An asynchronous reset discards
  // all buffered bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a_q <= ZERO_C;
      cnt_b_q <= ZERO_C;
      out_a_q <= 1'b0;
      out_b_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      out_a_q <= out_a_d;
      out_b_q <= out_b_d;
      valid_q <= bus.in_valid;
    end
  end

endmodule

// File: tb/tb_corr_sync.sv
// Directed bench for corr_sync. It uses one DEPTH=2 instance and one DEPTH=3
// instance. The expected values are worked out by hand from the reordering
// rules.
module tb_corr_sync;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  corr_sync_if #(.CW(2)) i2 ();
  corr_sync_if #(.CW(2)) i3 ();

  corr_sync #(.DEPTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(i2.slave));
  corr_sync #(.DEPTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(i3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One clock on the DEPTH=2 instance, then compare {valid,a,b} and both counters
  task automatic s2(input string tag, input logic v, input logic a, input logic b,
                    input logic m, input logic f, input logic [2:0] eo,
                    input int ea, input int eb);
    i2.in_valid = v; i2.in_a = a; i2.in_b = b; i2.mode = m; i2.flush = f;
    @(posedge clk);
    #1;
    chk({tag, ".out"}, int'({i2.out_valid, i2.out_a, i2.out_b}), int'(eo));
    chk({tag, ".cnt_a"}, int'(i2.cnt_a), ea);
    chk({tag, ".cnt_b"}, int'(i2.cnt_b), eb);
  endtask

  // Same for the DEPTH=3 instance
  task automatic s3(input string tag, input logic v, input logic a, input logic b,
                    input logic m, input logic f, input logic [2:0] eo,
                    input int ea, input int eb);
    i3.in_valid = v; i3.in_a = a; i3.in_b = b; i3.mode = m; i3.flush = f;
    @(posedge clk);
    #1;
    chk({tag, ".out"}, int'({i3.out_valid, i3.out_a, i3.out_b}), int'(eo));
    chk({tag, ".cnt_a"}, int'(i3.cnt_a), ea);
    chk({tag, ".cnt_b"}, int'(i3.cnt_b), eb);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    i2.in_valid = 1'b0; i2.in_a = 1'b0; i2.in_b = 1'b0; i2.mode = 1'b0; i2.flush = 1'b0;
    i3.in_valid = 1'b0; i3.in_a = 1'b0; i3.in_b = 1'b0; i3.mode = 1'b0; i3.flush = 1'b0;
    #12;
    chk("rst.out", int'({i2.out_valid, i2.out_a, i2.out_b}), 0);
    chk("rst.cnt", int'({i2.cnt_a, i2.cnt_b}), 0);
    chk("rst.busy", int'(i2.busy), 0);
    chk("rst3.out", int'({i3.out_valid, i3.out_a, i3.out_b}), 0);
    rst_n = 1'b1;

    // Sync: a lone A bit fills the buffer to DEPTH, then passes through
    s2("fill1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 1, 0);
    s2("fill2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 2, 0);
    s2("full",  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b110, 2, 0);
    s2("pair1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 1, 0);
    s2("pair2", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 0, 0);
    chk("pair2.busy", int'(i2.busy), 0);

    // Sync: hold, then pair up
    s2("hold", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 1, 0);
    chk("hold.busy", int'(i2.busy), 1);
    s2("match", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 0, 0);
    chk("match.busy", int'(i2.busy), 0);

    // Mirror direction, plus a pass-through while B is held
    s2("holdb", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 0, 1);
    s2("eq11",  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b111, 0, 1);
    s2("matchb", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b111, 0, 0);

    // in_valid gaps: counters hold and outputs read as zero
    s2("v1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 1, 0);
    s2("v0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1, 0);
    s2("v1b", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 2, 0);
    s2("drn1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 1, 0);
    s2("drn2", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 0, 0);

    // Desync: split overlapping ones, then re-emit them into empty slots
    s2("ds11a", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b101, 1, 0);
    s2("ds11b", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b101, 2, 0);
    s2("ds11c", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b110, 2, 1);
    s2("ds00a", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b110, 1, 1);
    s2("ds00b", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b110, 0, 1);
    s2("ds00c", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b101, 0, 0);
    s2("ds00d", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 0, 0);
    s2("dspass", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b110, 0, 0);

    // Desync saturation: both counters full, then overlap passes through
    s2("dsf1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b101, 1, 0);
    s2("dsf2", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b101, 2, 0);
    s2("dsf3", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b110, 2, 1);
    s2("dsf4", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b110, 2, 2);
    s2("dsf5", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b111, 2, 2);

    // Mode change keeps the contents; the sync rules then act on them
    s2("mchg", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b111, 2, 1);
    // Flush drains each stream on its own
    s2("fl1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b111, 1, 0);
    s2("fl2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'b110, 0, 0);
    s2("fl3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b110, 0, 0);

    // Async reset mid-operation clears everything without a clock edge
    s2("prer", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.out", int'({i2.out_valid, i2.out_a, i2.out_b}), 0);
    chk("arst.cnt_a", int'(i2.cnt_a), 0);
    chk("arst.busy", int'(i2.busy), 0);
    #1;
    rst_n = 1'b1;
    s2("postr", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 0, 1);
    s2("postr2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b111, 0, 0);
    i2.in_valid = 1'b0;

    // DEPTH=3: fill A to 3, then flush it out against zero inputs
    s3("d3f1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 1, 0);
    s3("d3f2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 2, 0);
    s3("d3f3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 3, 0);
    s3("d3full", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b110, 3, 0);
    s3("d3fl1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b110, 2, 0);
    s3("d3fl2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b110, 1, 0);
    s3("d3fl3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b110, 0, 0);
    s3("d3fl4", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b100, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/corr_sync.md
CORR_SYNC -- requirements
Module: corr_sync

Interface
REQ-001 Parameter DEPTH, default 2: per-stream save capacity (max buffered 1-bits); legal range 1..15.
REQ-002 Parameter CW, default $clog2(DEPTH+1): width of each save counter.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  qualifies in_a/in_b this cycle.
REQ-006 in_a  input  1  stochastic bitstream A.
REQ-007 in_b  input  1  stochastic bitstream B.
REQ-008 mode  input  1  0 = synchronise (drive SCC toward +1), 1 = desynchronise (drive SCC toward -1).
REQ-009 flush  input  1  release buffered 1-bits; overrides mode rules.
REQ-010 out_valid  output  1  registered copy of in_valid.
REQ-011 out_a  output  1  re-ordered stream A.
REQ-012 out_b  output  1  re-ordered stream B.
REQ-013 cnt_a  output  CW  saved 1-bits held for A.
REQ-014 cnt_b  output  CW  saved 1-bits held for B.
REQ-015 busy  output  1  combinational: (cnt_a != 0) or (cnt_b != 0).

Function
REQ-016 Latency: out_a/out_b/out_valid shall be registered, appearing exactly one cycle after the sampled inputs.
REQ-017 When in_valid=0: counters hold; next cycle out_valid=0, out_a=0, out_b=0.
REQ-018 When in_valid=1: the rules below are evaluated; priority is flush, then mode; each cycle changes each counter by at most 1.
REQ-019 Sync (mode=0), in_a=in_b: out = inputs, counters unchanged.
REQ-020 Sync, a=1 b=0: if cnt_b>0 -> out (1,1), cnt_b-1; else if cnt_a<DEPTH -> out (0,0), cnt_a+1; else (full) -> out (1,0), unchanged.
REQ-021 Sync, a=0 b=1: mirror of REQ-020 with A and B swapped.
REQ-022 Sync invariant: cnt_a and cnt_b shall never be simultaneously nonzero from mode=0 operation alone.
REQ-023 Desync (mode=1), a=1 b=1: if cnt_a<DEPTH -> out (0,1), cnt_a+1; else if cnt_b<DEPTH -> out (1,0), cnt_b+1; else -> out (1,1), unchanged.
REQ-024 Desync, a=0 b=0: if cnt_a>0 -> out (1,0), cnt_a-1; else if cnt_b>0 -> out (0,1), cnt_b-1; else -> out (0,0).
REQ-025 Desync, a!=b: out = inputs, counters unchanged.
REQ-026 Flush=1 (either mode): per stream independently, input 1 -> output 1, counter unchanged; input 0 with counter>0 -> output 1, counter-1; input 0 with counter=0 -> output 0.
REQ-027 mode may change on any cycle; the rules of the newly sampled mode apply immediately to existing counter contents; no counter is cleared by a mode change.
REQ-028 Conservation: per stream, (1s in with in_valid) = (1s out with out_valid) + counter, at every cycle boundary.
REQ-029 Counters saturate at DEPTH and at 0; no wrap-around under any input sequence.

Reset
REQ-030 On rst_n=0, cnt_a, cnt_b, out_a, out_b and out_valid shall clear to 0 immediately, independent of clk; busy=0.
REQ-031 Reset mid-operation shall discard buffered bits; the first valid input after rst_n deasserts is processed with counters at 0.

Verification
REQ-032 DEPTH=2, mode=0, (a,b)=(1,0),(1,0),(1,0) -> out (0,0),(0,0),(1,0); cnt_a 1,2,2.
REQ-033 DEPTH=2, mode=0, (1,0) then (0,1) -> out (0,0) then (1,1); cnt_a returns 1->0, busy low after.
REQ-034 DEPTH=2, mode=1, (1,1)x3 then (0,0)x3 -> out (0,1),(0,1),(1,0),(1,0),(1,0),(0,1); final counters 0.
REQ-035 DEPTH=3, cnt_a=3 via sync, then flush=1 with a=0 x4 -> out_a 1,1,1,0; cnt_a 2,1,0,0.
REQ-036 in_valid toggling 1,0,1 with (1,0) each cycle -> out_valid 1,0,1 delayed one cycle; cnt_a 1,1,2.
REQ-037 Random 10k-cycle streams, random mode/flush/in_valid, DEPTH in {1,2,7,15} -> REQ-028 and REQ-029 hold every cycle; sync mode SCC >= unbuffered SCC; async reset pulse mid-run clears all outputs same cycle.
